// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Brief    : Shared types and helpers for the 10-bit game-logic LFSR stream:
//            checker state encoding, feedback taps and feedback function.
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

   // Checker operating modes
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_e;

   // Feedback taps of the generator: bits 7, 4, 3 and 1
   localparam logic [9:0] c_LFSR_TAPS = 10'b00_1001_1010;

   // Length of the history register / generator state
   localparam int c_LFSR_W = 10;

   // Feedback bit the generator shifts into num[0] for a given state
   function automatic logic lfsr_fb(input logic [9:0] hist);
      return ^(hist & c_LFSR_TAPS);
   endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with synchronous clear; clear wins over a
//            same-cycle increment.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);

   localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] count_q;

   // Count up on inc, stick at all-ones, clear has priority
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + c_ONE;
      end
   end

   assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_checker
// Brief    : Bit-serial self-synchronising checker for the 10-bit LFSR
//            stream. Hunts, verifies a run of matching bits, then flywheels
//            on its own prediction while flagging and counting mismatches.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int GOOD_RUN = 16,
   parameter int BAD_MAX  = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk_22,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic             zero_lock,
   output logic [9:0]       num_est
);

   // Terminal values: the transition fires on the step that reaches the limit
   localparam logic [3:0] c_FILL_LAST = 4'(c_LFSR_W - 1);
   localparam logic [3:0] c_FILL_FULL = 4'(c_LFSR_W);
   localparam logic [7:0] c_GOOD_LAST = 8'(GOOD_RUN - 1);
   localparam logic [3:0] c_BAD_LAST  = 4'(BAD_MAX - 1);

   state_e       state_q;
   logic [9:0]   hist_q;
   logic [9:0]   hist_d;
   logic [3:0]   fill_q;
   logic [7:0]   run_q;
   logic [3:0]   bad_q;
   logic         locked_q;
   logic         err_pulse_q;
   logic         zero_lock_q;

   logic         w_exp;
   logic         w_mis;
   logic         w_err_inc;
   logic         w_enter_lock;
   logic         w_leave_lock;
   logic         w_locked_d;

   // Prediction, error detection and lock transitions for the current bit
   always_comb begin
      w_exp        = lfsr_fb(hist_q);
      w_mis        = in_bit ^ w_exp;
      w_err_inc    = in_valid && (state_q == LOCKED) && w_mis;
      w_enter_lock = in_valid && (state_q == SYNC) && (hist_q != '0) &&
                     !w_mis && (run_q == c_GOOD_LAST);
      w_leave_lock = w_err_inc && (bad_q == c_BAD_LAST);
      w_locked_d   = ((state_q == LOCKED) && !w_leave_lock) || w_enter_lock;
      // In LOCKED the register flywheels on its own prediction so that a
      // corrupted received bit never enters the history.
      hist_d       = hist_q;
      if (in_valid) begin
         hist_d = {hist_q[8:0], (state_q == LOCKED) ? w_exp : in_bit};
      end
   end

   // FSM, history register, fill/run/bad counters and registered flags
   always_ff @(posedge clk_22) begin
      if (rst) begin
         state_q     <= HUNT;
         hist_q      <= '0;
         fill_q      <= '0;
         run_q       <= '0;
         bad_q       <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         zero_lock_q <= 1'b0;
      end else begin
         err_pulse_q <= w_err_inc;
         if (in_valid) begin
            hist_q      <= hist_d;
            locked_q    <= w_locked_d;
            zero_lock_q <= (hist_d == '0) && !w_locked_d;
            case (state_q)
               HUNT: begin
                  if (fill_q == c_FILL_LAST) begin
                     fill_q  <= c_FILL_FULL;
                     run_q   <= '0;
                     state_q <= SYNC;
                  end else begin
                     fill_q <= fill_q + 4'd1;
                  end
               end
               SYNC: begin
                  // An all-zero history is a fixed point of the recurrence;
                  // it must never count toward lock.
                  if ((hist_q == '0) || w_mis) begin
                     run_q <= '0;
                  end else if (w_enter_lock) begin
                     run_q   <= '0;
                     bad_q   <= '0;
                     state_q <= LOCKED;
                  end else begin
                     run_q <= run_q + 8'd1;
                  end
               end
               LOCKED: begin
                  if (w_leave_lock) begin
                     fill_q  <= '0;
                     run_q   <= '0;
                     bad_q   <= '0;
                     state_q <= HUNT;
                  end else if (w_mis) begin
                     bad_q <= bad_q + 4'd1;
                  end else begin
                     bad_q <= '0;
                  end
               end
               default: begin
                  state_q <= HUNT;
               end
            endcase
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_err_cnt (
      .clk_i   (clk_22),
      .rst_i   (rst),
      .inc_i   (w_err_inc),
      .clr_i   (clear_cnt),
      .count_o (err_count)
   );

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign zero_lock = zero_lock_q;
   assign num_est   = hist_q;

endmodule : lfsr_checker
`default_nettype wire
